// File: rtl/spifi_resp_pkg.sv
// Shared types and opcode constants for the SPIFI flash responder.
package spifi_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_e;

    typedef enum logic {
        KIND_SINGLE,
        KIND_QUAD
    } kind_e;

    localparam logic [7:0] OPC_READ  = 8'h03;
    localparam logic [7:0] OPC_QREAD = 8'h6B;
    localparam logic [7:0] OPC_RDID  = 8'h9F;

endpackage

// File: rtl/spifi_resp_sync.sv
// Brings SCK and CS into the i_hclk domain: two synchroniser flops plus one
// history flop per line, producing single-cycle edge strobes.
module spifi_resp_sync (
    input  logic i_hclk,
    input  logic i_hnreset,
    input  logic i_sck,
    input  logic i_cs,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_n_sync,
    output logic o_cs_fall
);

    logic [2:0] sck_q;
    logic [2:0] cs_q;

    // Shift chains: [0] and [1] synchronise, [2] holds the previous synced value.
    // CS resets to the deasserted level so reset release never looks like a select.
    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            sck_q <= '0;
            cs_q  <= '1;
        end else begin
            sck_q <= {sck_q[1:0], i_sck};
            cs_q  <= {cs_q[1:0], i_cs};
        end
    end

    assign o_sck_rise  =  sck_q[1] & ~sck_q[2];
    assign o_sck_fall  = ~sck_q[1] &  sck_q[2];
    assign o_cs_n_sync =  cs_q[1];
    assign o_cs_fall   = ~cs_q[1] &  cs_q[2];

endmodule

// File: rtl/spifi_flash_resp.sv
// SPI/SPIFI flash responder: decodes opcode/address/dummy phases and returns
// data from a byte-wide synchronous backing memory, single (IO1) or quad.
// Optional JEDEC ID readback (opcode 0x9F) is enabled by SPIFI_RESP_JEDEC_EN.
module spifi_flash_resp
    import spifi_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DUMMY_CYC = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
    input  logic              i_hclk,
    input  logic              i_hnreset,
    input  logic              i_spifi_sck,
    input  logic              i_spifi_cs,
    input  logic [3:0]        i_spifi_so,
    input  logic [3:0]        i_spifi_soen,
    output logic [3:0]        o_spifi_si,
    output logic [3:0]        o_spifi_oe,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_busy,
    output logic              o_cmd_err
);

    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYC - 1);

    logic sck_rise, sck_fall, cs_n_sync, cs_fall;

    spifi_resp_sync u_sync (
        .i_hclk      (i_hclk),
        .i_hnreset   (i_hnreset),
        .i_sck       (i_spifi_sck),
        .i_cs        (i_spifi_cs),
        .o_sck_rise  (sck_rise),
        .o_sck_fall  (sck_fall),
        .o_cs_n_sync (cs_n_sync),
        .o_cs_fall   (cs_fall)
    );

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [22:0]       shin_q, shin_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        pref_q, pref_d;
    logic [7:0]        shout_q, shout_d;
    logic [3:0]        si_q, si_d;
    logic [3:0]        oe_q, oe_d;
    logic              rd_q, rd_d;
    logic              rd_dly_q, rd_dly_d;
    logic              err_q, err_d;
    logic              cont_q, cont_d;

    logic [23:0]       full_v;
    logic [7:0]        cur_byte;

    // Next-state, datapath and output logic for the whole transaction.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        shin_d   = shin_q;
        addr_d   = addr_q;
        shout_d  = shout_q;
        si_d     = si_q;
        oe_d     = oe_q;
        cont_d   = cont_q;
        rd_d     = 1'b0;
        err_d    = 1'b0;
        rd_dly_d = rd_q;
        pref_d   = rd_dly_q ? i_mem_rdata : pref_q;
        full_v   = {shin_q, i_spifi_so[0]};
        cur_byte = (cnt_q == 5'd0) ? pref_q : shout_q;

        if (cs_n_sync) begin
            state_d = IDLE;
            cnt_d   = '0;
            shin_d  = '0;
            shout_d = '0;
            si_d    = '0;
            oe_d    = '0;
            cont_d  = 1'b0;
        end else begin
            if (sck_rise && (|(i_spifi_soen & oe_q)) && !cont_q) begin
                err_d  = 1'b1;
                cont_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        shin_d  = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        shin_d = full_v[22:0];
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            case (full_v[7:0])
                                OPC_READ: begin
                                    state_d = ADDR;
                                    kind_d  = KIND_SINGLE;
                                end
                                OPC_QREAD: begin
                                    state_d = ADDR;
                                    kind_d  = KIND_QUAD;
                                end
`ifdef SPIFI_RESP_JEDEC_EN
                                OPC_RDID: state_d = ID;
`endif
                                default: begin
                                    state_d = IGNORE;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        shin_d = full_v[22:0];
                        if (cnt_q == 5'd23) begin
                            cnt_d  = '0;
                            addr_d = full_v[ADDR_W-1:0];
                            rd_d   = 1'b1;
                            if (kind_q == KIND_QUAD && DUMMY_CYC != 0)
                                state_d = DUMMY;
                            else
                                state_d = DATA;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d   = '0;
                            state_d = DATA;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    // cnt_q==0 marks a byte boundary: take the prefetched byte and
                    // immediately request the next one so it is ready in time.
                    if (sck_fall) begin
                        if (cnt_q == 5'd0) begin
                            addr_d = addr_q + 1'b1;
                            rd_d   = 1'b1;
                        end
                        if (kind_q == KIND_SINGLE) begin
                            si_d    = {2'b00, cur_byte[7], 1'b0};
                            shout_d = {cur_byte[6:0], 1'b0};
                            oe_d    = 4'b0010;
                            cnt_d   = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
                        end else begin
                            si_d    = cur_byte[7:4];
                            shout_d = {cur_byte[3:0], 4'b0000};
                            oe_d    = 4'b1111;
                            cnt_d   = (cnt_q == 5'd1) ? 5'd0 : cnt_q + 5'd1;
                        end
                    end
                end
`ifdef SPIFI_RESP_JEDEC_EN
                ID: begin
                    if (sck_fall) begin
                        si_d  = {2'b00, JEDEC_ID[5'd23 - cnt_q], 1'b0};
                        oe_d  = 4'b0010;
                        cnt_d = (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef SPIFI_RESP_JEDEC_EN
    // JEDEC_ID has no function in this build.
    logic unused_jedec;
    assign unused_jedec = ^JEDEC_ID;
`endif

    // Only IO0 carries controller data in the supported opcodes.
    logic unused_so;
    assign unused_so = ^i_spifi_so[3:1];

    // State and datapath registers.
    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state_q  <= IDLE;
            kind_q   <= KIND_SINGLE;
            cnt_q    <= '0;
            shin_q   <= '0;
            addr_q   <= '0;
            pref_q   <= '0;
            shout_q  <= '0;
            si_q     <= '0;
            oe_q     <= '0;
            rd_q     <= 1'b0;
            rd_dly_q <= 1'b0;
            err_q    <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            shin_q   <= shin_d;
            addr_q   <= addr_d;
            pref_q   <= pref_d;
            shout_q  <= shout_d;
            si_q     <= si_d;
            oe_q     <= oe_d;
            rd_q     <= rd_d;
            rd_dly_q <= rd_dly_d;
            err_q    <= err_d;
            cont_q   <= cont_d;
        end
    end

    assign o_spifi_si = si_q;
    assign o_spifi_oe = oe_q;
    assign o_mem_rd   = rd_q;
    assign o_mem_addr = addr_q;
    assign o_cmd_err  = err_q;
    assign o_busy     = ~cs_n_sync & (state_q != IDLE);

endmodule

// File: tb/tb_spifi_flash_resp.sv
// Directed self-checking bench for spifi_flash_resp (SCK = i_hclk / 16).
// Covers the JEDEC ID path when SPIFI_RESP_JEDEC_EN is defined.
module tb_spifi_flash_resp;

    logic        hclk;
    logic        hnreset;
    logic        sck;
    logic        cs;
    logic [3:0]  so;
    logic [3:0]  soen;
    logic [3:0]  si;
    logic [3:0]  oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    logic [23:0] rd_log [$];
    logic [7:0]  mem [logic [23:0]];

    spifi_flash_resp #(.ADDR_W(24), .DUMMY_CYC(8), .JEDEC_ID(24'hEF4018)) dut (
        .i_hclk       (hclk),
        .i_hnreset    (hnreset),
        .i_spifi_sck  (sck),
        .i_spifi_cs   (cs),
        .i_spifi_so   (so),
        .i_spifi_soen (soen),
        .o_spifi_si   (si),
        .o_spifi_oe   (oe),
        .o_mem_rd     (mem_rd),
        .o_mem_addr   (mem_addr),
        .i_mem_rdata  (mem_rdata),
        .o_busy       (busy),
        .o_cmd_err    (cmd_err)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Synchronous backing memory: data valid the cycle after the read strobe.
    always @(posedge hclk) begin
        if (mem_rd)
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    end

    // Log strobes away from the active edge.
    always @(negedge hclk) begin
        if (mem_rd)
            rd_log.push_back(mem_addr);
        if (cmd_err)
            err_cnt++;
    end

    // One SCK period; returns SI/OE as seen just before the rising edge.
    task automatic pulse(input logic [3:0] v, output logic [3:0] si_s, output logic [3:0] oe_s);
        so = v;
        #20;
        si_s = si;
        oe_s = oe;
        sck = 1'b1;
        #80;
        sck = 1'b0;
        #60;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] s, o;
        for (int i = 7; i >= 0; i--)
            pulse({3'b000, b[i]}, s, o);
    endtask

    task automatic send_addr(input logic [23:0] a, input int nbits);
        logic [3:0] s, o;
        for (int i = 0; i < nbits; i++)
            pulse({3'b000, a[23-i]}, s, o);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #40;
        cs = 1'b1;
        #100;
    endtask

    // Opcode 0x03 plus address, then nbits data clocks collecting IO1.
    task automatic read_single(input logic [23:0] a, input int nbits,
                               output logic [31:0] bits, output logic [3:0] oe_or,
                               output logic [3:0] oe_and);
        logic [3:0] s, o;
        cs_low();
        send_byte(8'h03);
        send_addr(a, 24);
        bits   = '0;
        oe_or  = '0;
        oe_and = '1;
        for (int i = 0; i < nbits; i++) begin
            pulse(4'h0, s, o);
            bits   = {bits[30:0], s[1]};
            oe_or  = oe_or | o;
            oe_and = oe_and & o;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({si, oe, mem_rd, mem_addr, busy, cmd_err} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_in: outputs=%h required 0", {si, oe, mem_rd, mem_addr, busy, cmd_err});
        end
        #50;
        hnreset = 1'b1;
        #50;
        n_checks++;
        if ({si, oe, mem_rd, mem_addr, busy, cmd_err} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_out: outputs=%h required 0", {si, oe, mem_rd, mem_addr, busy, cmd_err});
        end
    endtask

    task automatic test_single_read();
        logic [31:0] bits;
        logic [3:0]  oo, oa;
        logic [71:0] got;
        rd_log.delete();
        read_single(24'h000100, 16, bits, oo, oa);
        n_checks++;
        if (bits[15:0] !== 16'hA55A) begin
            n_fail++;
            $display("FAIL single_data: got %h required a55a", bits[15:0]);
        end
        n_checks++;
        if (oo !== 4'b0010 || oa !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_oe: or=%b and=%b required 0010", oo, oa);
        end
        got = (rd_log.size() >= 3) ? {rd_log[0], rd_log[1], rd_log[2]} : '1;
        n_checks++;
        if (got !== {24'h000100, 24'h000101, 24'h000102}) begin
            n_fail++;
            $display("FAIL single_rd_addr: got %h required 000100000101000102", got);
        end
        #40;
        cs = 1'b1;
        #30;
        n_checks++;
        if (oe !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cs_release: oe=%b busy=%b required 0000/0", oe, busy);
        end
        #70;
    endtask

    task automatic test_quad_wrap();
        logic [3:0]  s, o, dummy_oe, oo, oa;
        logic [23:0] nib;
        logic [71:0] got;
        rd_log.delete();
        cs_low();
        send_byte(8'h6B);
        send_addr(24'hFFFFFE, 24);
        dummy_oe = '0;
        for (int i = 0; i < 8; i++) begin
            pulse(4'h0, s, o);
            dummy_oe = dummy_oe | o;
        end
        nib = '0;
        oo  = '0;
        oa  = '1;
        for (int i = 0; i < 6; i++) begin
            pulse(4'h0, s, o);
            nib = {nib[19:0], s};
            oo  = oo | o;
            oa  = oa & o;
        end
        cs_high();
        n_checks++;
        if (dummy_oe !== 4'b0000) begin
            n_fail++;
            $display("FAIL quad_dummy_oe: got %b required 0000", dummy_oe);
        end
        n_checks++;
        if (nib !== 24'h123456) begin
            n_fail++;
            $display("FAIL quad_data: got %h required 123456", nib);
        end
        n_checks++;
        if (oo !== 4'b1111 || oa !== 4'b1111) begin
            n_fail++;
            $display("FAIL quad_oe: or=%b and=%b required 1111", oo, oa);
        end
        got = (rd_log.size() >= 3) ? {rd_log[0], rd_log[1], rd_log[2]} : '1;
        n_checks++;
        if (got !== {24'hFFFFFE, 24'hFFFFFF, 24'h000000}) begin
            n_fail++;
            $display("FAIL quad_wrap_addr: got %h required fffffeffffff000000", got);
        end
    endtask

    task automatic test_bad_opcode();
        logic [3:0]  s, o, oo;
        logic [31:0] bits;
        logic [3:0]  ro, ra;
        err_cnt = 0;
        cs_low();
        send_byte(8'h55);
        oo = '0;
        for (int i = 0; i < 8; i++) begin
            pulse(4'h0, s, o);
            oo = oo | o;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_busy: got %b required 1", busy);
        end
        cs_high();
        n_checks++;
        if (err_cnt !== 1) begin
            n_fail++;
            $display("FAIL bad_err_count: got %0d required 1", err_cnt);
        end
        n_checks++;
        if (oo !== 4'b0000) begin
            n_fail++;
            $display("FAIL bad_oe: got %b required 0000", oo);
        end
        read_single(24'h000200, 8, bits, ro, ra);
        cs_high();
        n_checks++;
        if (bits[7:0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL bad_then_read: got %h required c3", bits[7:0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] bits;
        logic [3:0]  ro, ra;
        rd_log.delete();
        cs_low();
        send_byte(8'h03);
        send_addr(24'h000000, 12);
        cs = 1'b1;
        #30;
        n_checks++;
        if (oe !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: oe=%b busy=%b required 0000/0", oe, busy);
        end
        n_checks++;
        if (rd_log.size() !== 0) begin
            n_fail++;
            $display("FAIL abort_no_read: got %0d reads required 0", rd_log.size());
        end
        #70;
        read_single(24'h000010, 8, bits, ro, ra);
        cs_high();
        n_checks++;
        if (bits[7:0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL abort_then_read: got %h required 3c", bits[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] bits;
        logic [3:0]  ro, ra;
        read_single(24'h000100, 4, bits, ro, ra);
        hnreset = 1'b0;
        #1;
        n_checks++;
        if ({si, oe, mem_rd, mem_addr, busy, cmd_err} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs=%h required 0", {si, oe, mem_rd, mem_addr, busy, cmd_err});
        end
        cs = 1'b1;
        #49;
        hnreset = 1'b1;
        #50;
        read_single(24'h000101, 8, bits, ro, ra);
        cs_high();
        n_checks++;
        if (bits[7:0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_then_read: got %h required 5a", bits[7:0]);
        end
    endtask

    task automatic test_contention();
        logic [31:0] bits;
        logic [3:0]  ro, ra;
        err_cnt = 0;
        soen = 4'b0010;
        read_single(24'h000100, 16, bits, ro, ra);
        cs_high();
        soen = 4'b0000;
        n_checks++;
        if (err_cnt !== 1) begin
            n_fail++;
            $display("FAIL contention_err: got %0d pulses required 1", err_cnt);
        end
        n_checks++;
        if (bits[15:0] !== 16'hA55A) begin
            n_fail++;
            $display("FAIL contention_data: got %h required a55a", bits[15:0]);
        end
    endtask

    task automatic test_jedec();
        logic [3:0]  s, o;
        logic [31:0] bits;
        err_cnt = 0;
        rd_log.delete();
        cs_low();
        send_byte(8'h9F);
        bits = '0;
        for (int i = 0; i < 32; i++) begin
            pulse(4'h0, s, o);
            bits = {bits[30:0], s[1]};
        end
        cs_high();
`ifdef SPIFI_RESP_JEDEC_EN
        n_checks++;
        if (bits !== 32'hEF4018EF) begin
            n_fail++;
            $display("FAIL jedec_id: got %h required ef4018ef", bits);
        end
        n_checks++;
        if (rd_log.size() !== 0 || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL jedec_side: reads=%0d errs=%0d required 0/0", rd_log.size(), err_cnt);
        end
`else
        n_checks++;
        if (err_cnt !== 1) begin
            n_fail++;
            $display("FAIL rdid_err: got %0d pulses required 1", err_cnt);
        end
        n_checks++;
        if (bits !== 32'h0) begin
            n_fail++;
            $display("FAIL rdid_quiet: got %h required 0", bits);
        end
`endif
    endtask

    initial begin
        mem[24'h000100] = 8'hA5;
        mem[24'h000101] = 8'h5A;
        mem[24'h000200] = 8'hC3;
        mem[24'h000010] = 8'h3C;
        mem[24'hFFFFFE] = 8'h12;
        mem[24'hFFFFFF] = 8'h34;
        mem[24'h000000] = 8'h56;
        hnreset = 1'b0;
        sck     = 1'b0;
        cs      = 1'b1;
        so      = 4'h0;
        soen    = 4'h0;
        #3;
        #20;
        test_reset();
        test_single_read();
        test_quad_wrap();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        test_contention();
        test_jedec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
